// File: rtl/ppudefs.sv
// Shared PPU-side definitions: OAM DMA state encoding and CPU register addresses.
package ppudefs;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;

endpackage

// File: rtl/sprite_dma_if.sv
// CPU-bus / OAM write-port bundle between the bus mux, the OAM DMA engine and OAM.
interface sprite_dma_if;

  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  bus_din;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  oam_din;
  logic        oam_wr;

  modport master (
    input  cpu_ce, cpu_addr, cpu_wr, cpu_dout, bus_din,
    output cpu_halt, dma_active, dma_addr, dma_rd, oam_din, oam_wr
  );

  modport slave (
    output cpu_ce, cpu_addr, cpu_wr, cpu_dout, bus_din,
    input  cpu_halt, dma_active, dma_addr, dma_rd, oam_din, oam_wr
  );

endinterface

// File: rtl/sprite_dma.sv
// OAM DMA engine: a CPU write to $4014 halts the CPU and copies page $PP00-$PPFF
// into OAM through its auto-incrementing data port, one byte per READ/WRITE pair.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// DMA_IDLE  | bus released, watching for a write to DMA_REG
// DMA_HALT  | CPU halted, first stall cycle
// DMA_ALIGN | extra stall so that every READ lands on an even CPU cycle
// DMA_READ  | drive {page,cnt} on the bus, capture bus_din at cycle end
// DMA_WRITE | present captured byte to OAM, strobe oam_wr on the closing cpu_ce
module sprite_dma
  import ppudefs::*;
#(
  parameter logic [15:0] DMA_REG      = DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_REG = OAM_DATA_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  sprite_dma_if.master  bus
);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       parity_q;
  logic       trig;

  assign trig = bus.cpu_wr && (bus.cpu_addr == DMA_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DMA_IDLE;
      page_q   <= 8'h00;
      cnt_q    <= 8'h00;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
    end else if (bus.cpu_ce) begin
      state_q  <= state_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      parity_q <= ~parity_q;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      DMA_IDLE: begin
        if (trig) begin
          page_d  = bus.cpu_dout;
          state_d = DMA_HALT;
        end
      end
      // parity_q=1 here means the following cycle is even, so READ can start
      DMA_HALT:  state_d = parity_q ? DMA_READ : DMA_ALIGN;
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ: begin
        data_d  = bus.bus_din;
        state_d = DMA_WRITE;
      end
      DMA_WRITE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == 8'hFF) ? DMA_IDLE : DMA_READ;
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_halt   = 1'b0;
    bus.dma_active = 1'b0;
    bus.dma_addr   = 16'h0000;
    bus.dma_rd     = 1'b0;
    bus.oam_din    = 8'h00;
    bus.oam_wr     = 1'b0;
    unique case (state_q)
      DMA_IDLE: ;
      DMA_HALT, DMA_ALIGN: begin
        bus.cpu_halt   = 1'b1;
        bus.dma_active = 1'b1;
      end
      DMA_READ: begin
        bus.cpu_halt   = 1'b1;
        bus.dma_active = 1'b1;
        bus.dma_addr   = {page_q, cnt_q};
        bus.dma_rd     = 1'b1;
      end
      DMA_WRITE: begin
        bus.cpu_halt   = 1'b1;
        bus.dma_active = 1'b1;
        bus.dma_addr   = OAM_DATA_REG;
        bus.oam_din    = data_q;
        // OAM latches on the clk that closes the CPU cycle
        bus.oam_wr     = bus.cpu_ce;
      end
      default: ;
    endcase
  end

endmodule
